// File: rtl/unidade_controle_pkg.sv
// rtl/unidade_controle_pkg.sv - opcodes, ALU codes, select codes and state encoding for the control unit
package unidade_controle_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b100;

  localparam logic [1:0] FONTE_B_REG = 2'b00;
  localparam logic [1:0] FONTE_B_UM  = 2'b01;
  localparam logic [1:0] FONTE_B_IMM = 2'b10;

  localparam logic [1:0] PC_ULA   = 2'b00;
  localparam logic [1:0] PC_ALVO  = 2'b01;
  localparam logic [1:0] PC_SALTO = 2'b10;

  typedef enum logic [3:0] {
    S_BUSCA    = 4'd0,
    S_DECOD    = 4'd1,
    S_EXEC     = 4'd2,
    S_ESCR_R   = 4'd3,
    S_END      = 4'd4,
    S_MEM_LE   = 4'd5,
    S_ESCR_M   = 4'd6,
    S_MEM_ESCR = 4'd7,
    S_DESVIO   = 4'd8,
    S_SALTO    = 4'd9,
    S_PARADO   = 4'd10
  } estado_t;

  function automatic logic eh_tipo_r(input logic [3:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/unidade_controle_ula.sv
// rtl/unidade_controle_ula.sv - decodificador_ula: opcode to ALU operation for the EXEC state
module decodificador_ula
  import unidade_controle_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] sinal_ula_o
);

  // Anything that is not R-type (addi in practice) uses the adder.
  always_comb begin
    sinal_ula_o = ULA_ADD;
    case (opcode_i)
      OP_AND:  sinal_ula_o = ULA_AND;
      OP_OR:   sinal_ula_o = ULA_OR;
      OP_ADD:  sinal_ula_o = ULA_ADD;
      OP_SUB:  sinal_ula_o = ULA_SUB;
      OP_SLT:  sinal_ula_o = ULA_SLT;
      default: sinal_ula_o = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multi-cycle control FSM for the 8-bit processor
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int LARGURA_INSTR = 8,
  parameter bit HABILITA_ERRO = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LARGURA_INSTR-1:0] instrucao,
  input  logic                     zero,
  output logic [2:0]               sinal_ula,
  output logic                     ula_fonte_a,
  output logic [1:0]               ula_fonte_b,
  output logic                     pc_escreve,
  output logic [1:0]               pc_fonte,
  output logic                     ir_escreve,
  output logic                     alvo_escreve,
  output logic                     mem_le,
  output logic                     mem_escreve,
  output logic                     reg_escreve,
  output logic                     mem_para_reg,
  output logic                     parado,
  output logic                     erro,
  output logic [3:0]               estado
);

  estado_t    estado_q, estado_d;
  logic       erro_q, erro_d;
  logic [3:0] opcode;
  logic [2:0] sinal_exec;
  logic       operandos_unused;

  assign opcode           = instrucao[LARGURA_INSTR-1 -: 4];
  assign operandos_unused = ^instrucao[LARGURA_INSTR-5:0];

  decodificador_ula u_decodificador_ula (
    .opcode_i    (opcode),
    .sinal_ula_o (sinal_exec)
  );

  always_comb begin
    estado_d = estado_q;
    erro_d   = erro_q;
    case (estado_q)
      S_BUSCA: estado_d = S_DECOD;
      S_DECOD: begin
        if (eh_tipo_r(opcode) || opcode == OP_ADDI) begin
          estado_d = S_EXEC;
        end else begin
          case (opcode)
            OP_LW, OP_SW: estado_d = S_END;
            OP_BEQ:       estado_d = S_DESVIO;
            OP_J:         estado_d = S_SALTO;
            OP_HALT:      estado_d = S_PARADO;
            default: begin
              if (HABILITA_ERRO) begin
                estado_d = S_PARADO;
                erro_d   = 1'b1;
              end else begin
                estado_d = S_BUSCA;
              end
            end
          endcase
        end
      end
      S_EXEC:     estado_d = S_ESCR_R;
      S_ESCR_R:   estado_d = S_BUSCA;
      S_END:      estado_d = (opcode == OP_LW) ? S_MEM_LE : S_MEM_ESCR;
      S_MEM_LE:   estado_d = S_ESCR_M;
      S_ESCR_M:   estado_d = S_BUSCA;
      S_MEM_ESCR: estado_d = S_BUSCA;
      S_DESVIO:   estado_d = S_BUSCA;
      S_SALTO:    estado_d = S_BUSCA;
      S_PARADO:   estado_d = S_PARADO;
      default:    estado_d = S_BUSCA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= S_BUSCA;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      erro_q   <= erro_d;
    end
  end

  // Outputs decode the state register; the address selects stay put through
  // the memory states so the ALU keeps presenting the effective address.
  always_comb begin
    sinal_ula    = ULA_ADD;
    ula_fonte_a  = 1'b0;
    ula_fonte_b  = FONTE_B_REG;
    pc_fonte     = PC_ULA;
    pc_escreve   = 1'b0;
    ir_escreve   = 1'b0;
    alvo_escreve = 1'b0;
    mem_le       = 1'b0;
    mem_escreve  = 1'b0;
    reg_escreve  = 1'b0;
    mem_para_reg = 1'b0;
    case (estado_q)
      S_BUSCA: begin
        mem_le      = 1'b1;
        ir_escreve  = 1'b1;
        pc_escreve  = 1'b1;
        ula_fonte_a = 1'b1;
        ula_fonte_b = FONTE_B_UM;
        pc_fonte    = PC_ULA;
      end
      S_DECOD: begin
        ula_fonte_a  = 1'b1;
        ula_fonte_b  = FONTE_B_IMM;
        alvo_escreve = 1'b1;
      end
      S_EXEC, S_ESCR_R: begin
        sinal_ula    = sinal_exec;
        ula_fonte_b  = (opcode == OP_ADDI) ? FONTE_B_IMM : FONTE_B_REG;
        reg_escreve  = (estado_q == S_ESCR_R);
      end
      S_END: ula_fonte_b = FONTE_B_IMM;
      S_MEM_LE: begin
        ula_fonte_b = FONTE_B_IMM;
        mem_le      = 1'b1;
      end
      S_ESCR_M: begin
        reg_escreve  = 1'b1;
        mem_para_reg = 1'b1;
      end
      S_MEM_ESCR: begin
        ula_fonte_b = FONTE_B_IMM;
        mem_escreve = 1'b1;
      end
      S_DESVIO: begin
        sinal_ula  = ULA_SUB;
        pc_fonte   = PC_ALVO;
        pc_escreve = zero;  // zero settles at the mid-cycle negedge
      end
      S_SALTO: begin
        pc_escreve = 1'b1;
        pc_fonte   = PC_SALTO;
      end
      default: ;
    endcase
    if (reset) begin
      pc_escreve   = 1'b0;
      ir_escreve   = 1'b0;
      alvo_escreve = 1'b0;
      mem_le       = 1'b0;
      mem_escreve  = 1'b0;
      reg_escreve  = 1'b0;
    end
  end

  assign parado = (estado_q == S_PARADO);
  assign erro   = erro_q;
  assign estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - scoreboard bench for unidade_controle
module tb_unidade_controle;
  import unidade_controle_pkg::*;

  typedef struct packed {
    logic [3:0] estado;
    logic [2:0] sinal;
    logic       fa;
    logic [1:0] fb;
    logic [1:0] pcf;
    logic       pcw, irw, alvo, mle, mes, regw, m2r, par, err;
  } obs_t;

  typedef struct {
    string      tag;
    obs_t       v;
    obs_t       m;
    bit         chk0;
    logic [3:0] st0;
    logic       err0;
  } item_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instrucao = 8'h00;
  logic       zero = 1'b0;

  logic [2:0] sinal_ula, sinal_ula_0;
  logic       ula_fonte_a, ula_fonte_a_0;
  logic [1:0] ula_fonte_b, ula_fonte_b_0;
  logic       pc_escreve, pc_escreve_0;
  logic [1:0] pc_fonte, pc_fonte_0;
  logic       ir_escreve, ir_escreve_0;
  logic       alvo_escreve, alvo_escreve_0;
  logic       mem_le, mem_le_0;
  logic       mem_escreve, mem_escreve_0;
  logic       reg_escreve, reg_escreve_0;
  logic       mem_para_reg, mem_para_reg_0;
  logic       parado, parado_0;
  logic       erro, erro_0;
  logic [3:0] estado, estado_0;

  obs_t obs;
  item_t fila[$];
  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  unidade_controle #(.LARGURA_INSTR(8), .HABILITA_ERRO(1'b1)) dut (
    .clock(clock), .reset(reset), .instrucao(instrucao), .zero(zero),
    .sinal_ula(sinal_ula), .ula_fonte_a(ula_fonte_a), .ula_fonte_b(ula_fonte_b),
    .pc_escreve(pc_escreve), .pc_fonte(pc_fonte), .ir_escreve(ir_escreve),
    .alvo_escreve(alvo_escreve), .mem_le(mem_le), .mem_escreve(mem_escreve),
    .reg_escreve(reg_escreve), .mem_para_reg(mem_para_reg), .parado(parado),
    .erro(erro), .estado(estado)
  );

  unidade_controle #(.LARGURA_INSTR(8), .HABILITA_ERRO(1'b0)) dut0 (
    .clock(clock), .reset(reset), .instrucao(instrucao), .zero(zero),
    .sinal_ula(sinal_ula_0), .ula_fonte_a(ula_fonte_a_0), .ula_fonte_b(ula_fonte_b_0),
    .pc_escreve(pc_escreve_0), .pc_fonte(pc_fonte_0), .ir_escreve(ir_escreve_0),
    .alvo_escreve(alvo_escreve_0), .mem_le(mem_le_0), .mem_escreve(mem_escreve_0),
    .reg_escreve(reg_escreve_0), .mem_para_reg(mem_para_reg_0), .parado(parado_0),
    .erro(erro_0), .estado(estado_0)
  );

  assign obs = {estado, sinal_ula, ula_fonte_a, ula_fonte_b, pc_fonte, pc_escreve,
                ir_escreve, alvo_escreve, mem_le, mem_escreve, reg_escreve,
                mem_para_reg, parado, erro};

  // Expected outputs per state, from the behavioural description of the unit.
  function automatic void modelo(input estado_t st, input logic [3:0] op, input logic z,
                                 input logic err, input bit rst, input bit desconhecido,
                                 output obs_t v, output obs_t m);
    v = '0;
    m = '0;
    m.estado = '1; m.sinal = '1;
    m.pcw = 1; m.irw = 1; m.alvo = 1; m.mle = 1; m.mes = 1; m.regw = 1;
    m.par = 1; m.err = 1;
    v.estado = st;
    v.sinal  = 3'b010;
    v.err    = err;
    case (st)
      S_BUSCA: begin
        v.mle = 1; v.irw = 1; v.pcw = 1;
        v.fa = 1; v.fb = 2'b01; v.pcf = 2'b00;
        m.fa = 1; m.fb = '1; m.pcf = '1;
      end
      S_DECOD: begin
        v.fa = 1; v.fb = 2'b10; v.alvo = 1;
        m.fa = 1; m.fb = '1;
      end
      S_EXEC, S_ESCR_R: begin
        v.fa = 0;
        v.fb = (op == 4'b0101) ? 2'b10 : 2'b00;
        v.sinal = (op <= 4'b0100) ? op[2:0] : 3'b010;
        m.fa = 1; m.fb = '1;
        if (st == S_ESCR_R) begin
          v.regw = 1; v.m2r = 0; m.m2r = 1;
        end
      end
      S_END, S_MEM_LE: begin
        v.fa = 0; v.fb = 2'b10;
        m.fa = 1; m.fb = '1;
        v.mle = (st == S_MEM_LE);
      end
      S_ESCR_M: begin
        v.regw = 1; v.m2r = 1; m.m2r = 1;
      end
      S_MEM_ESCR: v.mes = 1;
      S_DESVIO: begin
        v.fa = 0; v.fb = 2'b00; v.sinal = 3'b011; v.pcf = 2'b01; v.pcw = z;
        m.fa = 1; m.fb = '1; m.pcf = '1;
      end
      S_SALTO: begin
        v.pcw = 1; v.pcf = 2'b10; m.pcf = '1;
      end
      S_PARADO: v.par = 1;
      default: ;
    endcase
    if (rst) begin
      v.pcw = 0; v.irw = 0; v.alvo = 0; v.mle = 0; v.mes = 0; v.regw = 0;
    end
    if (desconhecido) begin
      m.estado = '0; m.sinal = '0; m.par = 0; m.err = 0;
      m.fa = 0; m.fb = '0; m.pcf = '0; m.m2r = 0;
    end
  endfunction

  task automatic push(input string tag, input estado_t st, input logic err, input bit rst = 0,
                      input bit desconhecido = 0, input bit chk0 = 0,
                      input estado_t st0 = S_BUSCA, input logic err0 = 0);
    item_t it;
    it.tag  = tag;
    modelo(st, instrucao[7:4], zero, err, rst, desconhecido, it.v, it.m);
    it.chk0 = chk0;
    it.st0  = st0;
    it.err0 = err0;
    fila.push_back(it);
  endtask

  task automatic check_front();
    item_t it;
    total++;
    assert (fila.size() > 0) passed++;
    else $error("FAIL scoreboard_empty observed=%h expected=queued_item", obs);
    if (fila.size() == 0) return;
    it = fila.pop_front();
    total++;
    assert ((obs & it.m) === (it.v & it.m)) passed++;
    else $error("FAIL %s observed=%h expected=%h mask=%h", it.tag, obs & it.m, it.v & it.m, it.m);
    if (it.chk0) begin
      total++;
      assert ({estado_0, erro_0, parado_0} === {it.st0, it.err0, it.st0 == S_PARADO}) passed++;
      else $error("FAIL %s_noerr observed=%h/%b expected=%h/%b", it.tag, estado_0, erro_0,
                  it.st0, it.err0);
    end
  endtask

  task automatic drain();
    while (fila.size() > 0) begin
      @(negedge clock);
      check_front();
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input bit conhecido = 0, input estado_t st = S_BUSCA);
    reset = 1'b1;
    push("reset_cycle", st, 1'b0, 1, !conhecido);
    @(negedge clock);
    check_front();
    @(posedge clock);
    #1;
    push("reset_busca", S_BUSCA, 1'b0, 1);
    @(negedge clock);
    check_front();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // R-type opcodes 0000..0100, including add and slt
    for (int k = 0; k < 5; k++) begin
      instrucao = {k[3:0], 4'h7};
      push("r_busca", S_BUSCA, 0);
      push("r_decod", S_DECOD, 0);
      push("r_exec", S_EXEC, 0);
      push("r_escr", S_ESCR_R, 0);
      push("r_volta", S_BUSCA, 0);
      drain();
      do_reset();
    end

    instrucao = 8'h5A;
    push("addi_busca", S_BUSCA, 0);
    push("addi_decod", S_DECOD, 0);
    push("addi_exec", S_EXEC, 0);
    push("addi_escr", S_ESCR_R, 0);
    push("addi_volta", S_BUSCA, 0);
    drain();
    do_reset();

    instrucao = 8'h61;
    push("lw_busca", S_BUSCA, 0);
    push("lw_decod", S_DECOD, 0);
    push("lw_end", S_END, 0);
    push("lw_memle", S_MEM_LE, 0);
    push("lw_escrm", S_ESCR_M, 0);
    push("lw_volta", S_BUSCA, 0);
    drain();
    do_reset();

    instrucao = 8'h72;
    push("sw_busca", S_BUSCA, 0);
    push("sw_decod", S_DECOD, 0);
    push("sw_end", S_END, 0);
    push("sw_memescr", S_MEM_ESCR, 0);
    push("sw_volta", S_BUSCA, 0);
    drain();
    do_reset();

    instrucao = 8'h83;
    zero = 1'b1;
    push("beq1_busca", S_BUSCA, 0);
    push("beq1_decod", S_DECOD, 0);
    push("beq1_desvio", S_DESVIO, 0);
    push("beq1_volta", S_BUSCA, 0);
    drain();
    do_reset();

    zero = 1'b0;
    push("beq0_busca", S_BUSCA, 0);
    push("beq0_decod", S_DECOD, 0);
    push("beq0_desvio", S_DESVIO, 0);
    push("beq0_volta", S_BUSCA, 0);
    drain();
    do_reset();

    instrucao = 8'h94;
    push("j_busca", S_BUSCA, 0);
    push("j_decod", S_DECOD, 0);
    push("j_salto", S_SALTO, 0);
    push("j_volta", S_BUSCA, 0);
    drain();
    do_reset();

    instrucao = 8'hA0;
    push("ilegal_busca", S_BUSCA, 0, 0, 0, 1, S_BUSCA, 0);
    push("ilegal_decod", S_DECOD, 0, 0, 0, 1, S_DECOD, 0);
    push("ilegal_parado", S_PARADO, 1, 0, 0, 1, S_BUSCA, 0);
    push("ilegal_fica", S_PARADO, 1);
    drain();
    do_reset();

    // Reset arriving mid-lw, while in MEM_LE
    instrucao = 8'h61;
    push("rstlw_busca", S_BUSCA, 0);
    push("rstlw_decod", S_DECOD, 0);
    push("rstlw_end", S_END, 0);
    drain();
    do_reset(1, S_MEM_LE);

    instrucao = 8'hF0;
    push("halt_busca", S_BUSCA, 0);
    push("halt_decod", S_DECOD, 0);
    for (int k = 0; k < 20; k++) push("halt_parado", S_PARADO, 0);
    drain();
    do_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
